// File: rtl/mem_test_pkg.sv
// Shared definitions for the memory test responder and mem_test_sm.
// Holds the responder state encoding, byte-enable width helpers and
// the status codes mem_test_sm already reports.
package mem_test_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        CONFIRM = 3'd4,
        RELEASE = 3'd5
    } resp_state_t;

    localparam int DEF_WORD_WIDTH = 32;
    localparam int BE_WIDTH       = DEF_WORD_WIDTH / 8;

    // Status codes shared with mem_test_sm.
    localparam logic [3:0] STATE_CLEAR    = 4'h0;
    localparam logic [3:0] STATE_FINISHED = 4'hf;

    function automatic int be_width(input int word_width);
        return word_width / 8;
    endfunction

endpackage

// File: rtl/mem_test_responder.sv
// Memory-side responder for mem_test_sm: turns level-held write/read
// requests into single Avalon-MM pipelined transactions and returns a
// one-cycle confirm pulse plus the last read data (pattern_rb).
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   write, read           requests from mem_test_sm, held until confirm
//   gen_address, gen_word word address and write data / expected pattern
//   confirm               one-cycle completion pulse
//   pattern_rb            last captured read data
//   busy                  high outside IDLE
//   avm_*                 Avalon-MM pipelined master port
//   timeout_err           sticky timeout flag
//
// Optional feature macro: MEM_TEST_RESPONDER_TIMEOUT_EN
//   Defined: wait states give up after TIMEOUT_CYCLES cycles.
//   Undefined: waits indefinitely, timeout_err tied low.
module mem_test_responder
    import mem_test_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORD_WIDTH     = 32,
    parameter int ADDR_SHIFT     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write,
    input  logic                    read,
    input  logic [ADDR_WIDTH-1:0]   gen_address,
    input  logic [WORD_WIDTH-1:0]   gen_word,
    output logic                    confirm,
    output logic [WORD_WIDTH-1:0]   pattern_rb,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   avm_address,
    output logic                    avm_write,
    output logic                    avm_read,
    output logic [WORD_WIDTH-1:0]   avm_writedata,
    output logic [WORD_WIDTH/8-1:0] avm_byteenable,
    input  logic                    avm_waitrequest,
    input  logic [WORD_WIDTH-1:0]   avm_readdata,
    input  logic                    avm_readdatavalid,
    output logic                    timeout_err
);

    localparam int BW = be_width(WORD_WIDTH);

    if (WORD_WIDTH % 8 != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("mem_test_responder: bad WORD_WIDTH or TIMEOUT_CYCLES");
    end

    resp_state_t state, state_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_WIDTH-1:0] data_q;
    logic [WORD_WIDTH-1:0] rb_q;
    logic                  latch_req;
    logic                  capture_rd;
    logic                  timed_out;
    logic                  expired;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and Moore outputs
    always_comb begin
        state_next     = state;
        confirm        = 1'b0;
        busy           = 1'b1;
        avm_write      = 1'b0;
        avm_read       = 1'b0;
        avm_byteenable = '0;
        latch_req      = 1'b0;
        capture_rd     = 1'b0;
        timed_out      = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                // Write has priority when both requests are up.
                if (write) begin
                    latch_req  = 1'b1;
                    state_next = WR_REQ;
                end else if (read) begin
                    latch_req  = 1'b1;
                    state_next = RD_REQ;
                end
            end
            WR_REQ: begin
                avm_write      = 1'b1;
                avm_byteenable = {BW{1'b1}};
                if (!avm_waitrequest) begin
                    state_next = CONFIRM;
                end else if (expired) begin
                    timed_out  = 1'b1;
                    state_next = CONFIRM;
                end
            end
            RD_REQ: begin
                avm_read       = 1'b1;
                avm_byteenable = {BW{1'b1}};
                if (!avm_waitrequest) begin
                    state_next = RD_WAIT;
                end else if (expired) begin
                    timed_out  = 1'b1;
                    state_next = CONFIRM;
                end
            end
            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    capture_rd = 1'b1;
                    state_next = CONFIRM;
                end else if (expired) begin
                    timed_out  = 1'b1;
                    state_next = CONFIRM;
                end
            end
            CONFIRM: begin
                confirm    = 1'b1;
                state_next = RELEASE;
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch and readback register
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
            rb_q   <= '0;
        end else begin
            if (latch_req) begin
                addr_q <= gen_address << ADDR_SHIFT;
                data_q <= gen_word;
            end
            if (capture_rd) begin
                rb_q <= avm_readdata;
            end else if (timed_out && state != WR_REQ) begin
                // Report the expected pattern so the checker sees no flips.
                rb_q <= data_q;
            end
        end
    end

    assign avm_address   = addr_q;
    assign avm_writedata = data_q;
    assign pattern_rb    = rb_q;

`ifdef MEM_TEST_RESPONDER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] cnt;
    logic             err_q;

    assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_next != state) begin
                cnt <= '0;
            end else if (state inside {WR_REQ, RD_REQ, RD_WAIT}) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (timed_out) begin
                err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = err_q;
`else
    assign expired     = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
